// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the asynchronous FIFO: push request, read-domain Gray pointer,
// RAM write port and write-domain status flags.
interface fifo_wr_ctrl_if #(
  parameter int a_width = 4
);
  logic               wr_req;
  logic [a_width:0]   rd_gray_ptr;
  logic               wr_en;
  logic [a_width-1:0] wr_addr;
  logic [a_width:0]   wr_gray_ptr;
  logic               full;
  logic               almost_full;
  logic [a_width:0]   wr_level;
  logic               overflow;

  modport master (
    output wr_req, rd_gray_ptr,
    input  wr_en, wr_addr, wr_gray_ptr, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_req, rd_gray_ptr,
    output wr_en, wr_addr, wr_gray_ptr, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller for the asynchronous FIFO: binary/Gray write pointers,
// read-pointer synchroniser, full / almost_full / level and sticky overflow.
module fifo_wr_ctrl #(
  parameter int a_width     = 4,
  parameter int afull_level = 14
) (
  input logic           Clk,
  input logic           Rst,
  fifo_wr_ctrl_if.slave bus
);
  localparam logic [a_width:0] AFULL = (a_width + 1)'(afull_level);

  logic [a_width:0] wbin_reg;
  logic [a_width:0] wbin_next;
  logic [a_width:0] wgray_reg;
  logic [a_width:0] wgray_next;
  logic [a_width:0] rq1_reg;
  logic [a_width:0] rq2_reg;
  logic [a_width:0] rbin_s;
  logic [a_width:0] level_reg;
  logic [a_width:0] level_next;
  logic             full_reg;
  logic             full_next;
  logic             afull_reg;
  logic             ovf_reg;
  logic             wr_en;

  // Rst gates the enable directly so no RAM write slips through during reset.
  assign wr_en      = bus.wr_req & ~full_reg & ~Rst;
  assign wbin_next  = wbin_reg + {{a_width{1'b0}}, wr_en};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi <= a_width; gi++) begin : g_g2b
      assign rbin_s[gi] = ^rq2_reg[a_width:gi];
    end
  endgenerate

  assign level_next = wbin_next - rbin_s;
  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
  assign full_next  = (wgray_next == {~rq2_reg[a_width:a_width-1], rq2_reg[a_width-2:0]});

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wbin_reg  <= '0;
      wgray_reg <= '0;
      rq1_reg   <= '0;
      rq2_reg   <= '0;
      level_reg <= '0;
      full_reg  <= 1'b0;
      afull_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      wbin_reg  <= wbin_next;
      wgray_reg <= wgray_next;
      rq1_reg   <= bus.rd_gray_ptr;
      rq2_reg   <= rq1_reg;
      level_reg <= level_next;
      full_reg  <= full_next;
      afull_reg <= (level_next >= AFULL);
      if (bus.wr_req & full_reg) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wbin_reg[a_width-1:0];
  assign bus.wr_gray_ptr = wgray_reg;
  assign bus.full        = full_reg;
  assign bus.almost_full = afull_reg;
  assign bus.wr_level    = level_reg;
  assign bus.overflow    = ovf_reg;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: occupancy-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_wr_ctrl;
  localparam int AW    = 4;
  localparam int AF    = 14;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  fifo_wr_ctrl_if #(.a_width(AW)) bus ();

  fifo_wr_ctrl #(.a_width(AW), .afull_level(AF)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int g2b(input int g);
    int b;
    b = 0;
    for (int i = AW; i >= 0; i--) b = b | ((((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i);
    return b;
  endfunction

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  // Reference model: count of accepted pushes, and the read pointer as the write
  // domain sees it two edges after it was presented.
  int wptr_m;
  int seen1_m, seen2_m;
  int occ_m;
  bit full_m, af_m, ovf_m;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr_m = 0; seen1_m = 0; seen2_m = 0; occ_m = 0;
      full_m = 0; af_m = 0; ovf_m = 0;
    end else begin
      if (bus.wr_req && full_m) ovf_m = 1;
      if (bus.wr_req && !full_m) wptr_m = (wptr_m + 1) % PMOD;
      occ_m   = (wptr_m + PMOD - g2b(seen2_m)) % PMOD;
      full_m  = (occ_m == DEPTH);
      af_m    = (occ_m >= AF);
      seen2_m = seen1_m;
      seen1_m = int'(bus.rd_gray_ptr);
    end
  end

  int cyc;
  always @(negedge Clk) begin
    cyc++;
    if (bus.wr_req)
      $display("txn cyc=%0d rst=%0b rd_gray=%b en=%0b addr=%0d level=%0d full=%0b",
               cyc, Rst, bus.rd_gray_ptr, bus.wr_en, bus.wr_addr, bus.wr_level, bus.full);
    chk("wr_en",       int'(bus.wr_en),       int'(bus.wr_req && !full_m && !Rst));
    chk("wr_addr",     int'(bus.wr_addr),     wptr_m % DEPTH);
    chk("wr_gray_ptr", int'(bus.wr_gray_ptr), b2g(wptr_m));
    chk("full",        int'(bus.full),        int'(full_m));
    chk("almost_full", int'(bus.almost_full), int'(af_m));
    chk("wr_level",    int'(bus.wr_level),    occ_m);
    chk("overflow",    int'(bus.overflow),    int'(ovf_m));
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_gray_ptr = '0;
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    Rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_gray_ptr = '0;
    tick();
    tick();
    Rst = 1'b0;
    chk("rst_level", int'(bus.wr_level), 0);
    chk("rst_gray", int'(bus.wr_gray_ptr), 0);
    chk("rst_full", int'(bus.full), 0);

    // T1: sixteen pushes fill the FIFO
    bus.wr_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t1_addr", int'(bus.wr_addr), i);
      tick();
    end
    chk("t1_full", int'(bus.full), 1);
    chk("t1_gray", int'(bus.wr_gray_ptr), 5'b11000);
    chk("t1_level", int'(bus.wr_level), 16);
    chk("t1_afull", int'(bus.almost_full), 1);

    // T2: push while full is rejected and sets overflow
    chk("t2_wr_en", int'(bus.wr_en), 0);
    tick();
    chk("t2_overflow", int'(bus.overflow), 1);
    chk("t2_addr", int'(bus.wr_addr), 0);
    chk("t2_gray", int'(bus.wr_gray_ptr), 5'b11000);
    bus.wr_req = 1'b0;
    tick();
    chk("t2_overflow_sticky", int'(bus.overflow), 1);

    // T4: read pointer moves to 4; full drops on the third edge
    bus.rd_gray_ptr = 5'b00110;
    tick();
    chk("t4_full_e1", int'(bus.full), 1);
    tick();
    chk("t4_full_e2", int'(bus.full), 1);
    tick();
    chk("t4_full_e3", int'(bus.full), 0);
    chk("t4_level", int'(bus.wr_level), 12);
    chk("t4_afull", int'(bus.almost_full), 0);
    bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    chk("t4_level_push", int'(bus.wr_level), 13);
    tick();

    // T3: almost_full threshold
    do_reset();
    chk("t3_overflow_cleared", int'(bus.overflow), 0);
    bus.wr_req = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 13) begin
        chk("t3_afull_13", int'(bus.almost_full), 0);
        chk("t3_level_13", int'(bus.wr_level), 13);
      end
    end
    chk("t3_afull_14", int'(bus.almost_full), 1);
    chk("t3_level_14", int'(bus.wr_level), 14);
    chk("t3_full_14", int'(bus.full), 0);
    bus.wr_req = 1'b0;

    // T5: reader trails by one cycle; 40 pushes wrap the address twice
    do_reset();
    for (int i = 0; i < 40; i++) begin
      bus.rd_gray_ptr = (i == 0) ? 5'd0 : 5'(b2g((i - 1) % PMOD));
      bus.wr_req = 1'b1;
      chk("t5_addr", int'(bus.wr_addr), i % DEPTH);
      tick();
    end
    chk("t5_gray", int'(bus.wr_gray_ptr), 5'b01100);
    chk("t5_addr_end", int'(bus.wr_addr), 8);
    chk("t5_level", int'(bus.wr_level), 4);
    chk("t5_full", int'(bus.full), 0);

    // T6: asynchronous reset in the middle of a burst
    tick();
    tick();
    #2;
    Rst = 1'b1;
    #1;
    chk("t6_wr_en", int'(bus.wr_en), 0);
    chk("t6_addr", int'(bus.wr_addr), 0);
    chk("t6_level", int'(bus.wr_level), 0);
    chk("t6_gray", int'(bus.wr_gray_ptr), 0);
    bus.rd_gray_ptr = '0;
    @(posedge Clk);
    #3;
    Rst = 1'b0;
    #1;
    chk("t6_first_en", int'(bus.wr_en), 1);
    chk("t6_first_addr", int'(bus.wr_addr), 0);
    tick();
    chk("t6_next_addr", int'(bus.wr_addr), 1);
    chk("t6_next_level", int'(bus.wr_level), 1);
    bus.wr_req = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
